// File: rtl/riu_pkg.sv
// Shared constants and types for the RIU GPIO port: CSR addresses, bus width,
// 7-segment glyph table and the switch-debounce state encoding.
package riu_pkg;

  localparam logic [11:0] CSR_HEX = 12'hF02;
  localparam logic [11:0] CSR_SW  = 12'hF00;
  localparam int          GPIO_W  = 32;

  // Active-low segments, bit order gfedcba (bit0 = segment a).
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam seg7_t SEG7_BLANK_ZERO = 7'h40;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-glyph decoder for one active-low 7-segment digit.
module hex7seg
  import riu_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG7_GLYPH[nibble];
  end

endmodule

// File: rtl/riu_gpio_port.sv
// GPIO far end of the control unit: latches csrrw-hex writes onto eight 7-seg
// digits and returns synchronised, debounced board switches for csrrw-sw reads.
module riu_gpio_port
  import riu_pkg::*;
#(
  parameter int NUM_SW          = 18,
  parameter int NUM_HEX         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gpio_we,
  input  logic [GPIO_W-1:0]      gpio_out,
  input  logic [NUM_SW-1:0]      sw_raw,
  output logic [GPIO_W-1:0]      sw_val,
  output logic                   sw_changed,
  output logic [GPIO_W-1:0]      hex_reg,
  output logic [7*NUM_HEX-1:0]   hex_seg
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Display write path
  // ---------------------------------------------------------------------------
  logic [7*NUM_HEX-1:0] seg_dec;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_reg <= '0;
    end else if (gpio_we) begin
      hex_reg <= gpio_out;
    end
  end

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (hex_reg[4*i +: 4]),
      .seg    (seg_dec[7*i +: 7])
    );
  end

  // NOTE: the output register is reset to a defined glyph so the display never
  // shows garbage; it is a plain register bank, not a RAM, so reset is cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_seg <= {NUM_HEX{SEG7_BLANK_ZERO}};
    end else begin
      hex_seg <= seg_dec;
    end
  end

  // ---------------------------------------------------------------------------
  // Switch path: two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0] sync_meta;
  logic [NUM_SW-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM with a single shared stability counter
  // ---------------------------------------------------------------------------
  db_state_t         state;
  db_state_t         state_nxt;
  logic [NUM_SW-1:0] candidate;
  logic [NUM_SW-1:0] candidate_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_SW-1:0] sw_stable;
  logic [NUM_SW-1:0] sw_stable_nxt;
  logic              changed_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DB_IDLE;
      candidate  <= '0;
      cnt        <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      state      <= state_nxt;
      candidate  <= candidate_nxt;
      cnt        <= cnt_nxt;
      sw_stable  <= sw_stable_nxt;
      sw_changed <= changed_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    candidate_nxt = candidate;
    cnt_nxt       = cnt;
    sw_stable_nxt = sw_stable;
    changed_nxt   = 1'b0;

    unique case (state)
      DB_IDLE: begin
        if (sync != candidate) begin
          candidate_nxt = sync;
          cnt_nxt       = '0;
          state_nxt     = DB_COUNT;
        end
      end
      DB_COUNT: begin
        // Any bit moving while counting restarts the stability window.
        if (sync != candidate) begin
          candidate_nxt = sync;
          cnt_nxt       = '0;
        end else if (cnt == CNT_LAST) begin
          sw_stable_nxt = candidate;
          changed_nxt   = (candidate != sw_stable);
          state_nxt     = DB_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_IDLE;
      end
    endcase
  end

  // Zero-extension keeps the unused upper CSR bits at 0.
  assign sw_val = GPIO_W'(sw_stable);

endmodule

// File: tb/tb_riu_gpio_port.sv
// Directed bench for riu_gpio_port with a small expected-value scoreboard:
// hex write path, glyph decode, debounce timing, glitch rejection and reset.
module tb_riu_gpio_port;

  localparam int NUM_SW  = 18;
  localparam int NUM_HEX = 8;
  localparam int DB      = 4;

  // Reference glyphs, active-low gfedcba.
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 gpio_we = 1'b0;
  logic [31:0]          gpio_out = '0;
  logic [NUM_SW-1:0]    sw_raw = '0;
  logic [31:0]          sw_val;
  logic                 sw_changed;
  logic [31:0]          hex_reg;
  logic [7*NUM_HEX-1:0] hex_seg;

  riu_gpio_port #(
    .NUM_SW          (NUM_SW),
    .NUM_HEX         (NUM_HEX),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_we    (gpio_we),
    .gpio_out   (gpio_out),
    .sw_raw     (sw_raw),
    .sw_val     (sw_val),
    .sw_changed (sw_changed),
    .hex_reg    (hex_reg),
    .hex_seg    (hex_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s got=%h want=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_digits(input string tag, input logic [31:0] word);
    for (int i = 0; i < NUM_HEX; i++) begin
      push($sformatf("%s_d%0d", tag, i), 32'(GLY[word[4*i +: 4]]));
    end
  endtask

  task automatic check_digits();
    for (int i = 0; i < NUM_HEX; i++) begin
      pop_check(32'(hex_seg[7*i +: 7]));
    end
  endtask

  task automatic check_sw(input string tag, input logic [31:0] val, input logic chg);
    push({tag, "_val"}, val);
    push({tag, "_chg"}, 32'(chg));
    pop_check(sw_val);
    pop_check(32'(sw_changed));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    tick(2);
    push("por_hex_reg", 32'h0);
    pop_check(hex_reg);
    push_digits("por", 32'h0);
    check_digits();
    check_sw("por_sw", 32'h0, 1'b0);
    rst = 1'b0;
    tick(2);

    // Single write; decode lags hex_reg by one cycle.
    gpio_we  = 1'b1;
    gpio_out = 32'h0123_ABCD;
    tick();
    gpio_we  = 1'b0;
    gpio_out = 32'h5555_5555;
    push("wr_hex_reg", 32'h0123_ABCD);
    pop_check(hex_reg);
    push("wr_seg_lag_d0", 32'h40);
    pop_check(32'(hex_seg[6:0]));
    tick();
    push_digits("wr", 32'h0123_ABCD);
    check_digits();
    push("wr_hold", 32'h0123_ABCD);
    pop_check(hex_reg);

    // Back-to-back writes, then an ignored gpio_out.
    gpio_we  = 1'b1;
    gpio_out = 32'hFFFF_FFFF;
    tick();
    push("b2b_first", 32'hFFFF_FFFF);
    pop_check(hex_reg);
    gpio_out = 32'h0;
    tick();
    push("b2b_second", 32'h0);
    pop_check(hex_reg);
    push_digits("b2b_ff", 32'hFFFF_FFFF);
    check_digits();
    gpio_we  = 1'b0;
    gpio_out = 32'h1234;
    tick();
    push("b2b_ignored", 32'h0);
    pop_check(hex_reg);
    tick();
    push_digits("b2b_final", 32'h0);
    check_digits();

    // Stable switch change: visible exactly 7 cycles later.
    sw_raw = 18'h2A5A5;
    tick(6);
    check_sw("sw_early", 32'h0, 1'b0);
    tick();
    check_sw("sw_accept", 32'h0002_A5A5, 1'b1);
    tick();
    check_sw("sw_pulse_end", 32'h0002_A5A5, 1'b0);

    // Back to zero.
    sw_raw = '0;
    tick(7);
    check_sw("sw_zero", 32'h0, 1'b1);
    tick();

    // Three-cycle glitch: count starts, then restarts when the pulse ends.
    sw_raw = 18'h1;
    tick(3);
    sw_raw = '0;
    push("gl_cnt_capture", 32'd0);
    pop_check(32'(dut.cnt));
    push("gl_cand", 32'h1);
    pop_check(32'(dut.candidate));
    tick(2);
    push("gl_cnt_two", 32'd2);
    pop_check(32'(dut.cnt));
    tick();
    push("gl_cnt_restart", 32'd0);
    pop_check(32'(dut.cnt));
    push("gl_cand_back", 32'h0);
    pop_check(32'(dut.candidate));
    for (int i = 0; i < 6; i++) begin
      tick();
      check_sw($sformatf("gl_quiet%0d", i), 32'h0, 1'b0);
    end

    // Hex write during a switch debounce.
    sw_raw = 18'h3FFFF;
    tick(2);
    gpio_we  = 1'b1;
    gpio_out = 32'hDEAD_BEEF;
    tick();
    gpio_we  = 1'b0;
    push("cc_hex_reg", 32'hDEAD_BEEF);
    pop_check(hex_reg);
    tick();
    push_digits("cc", 32'hDEAD_BEEF);
    check_digits();
    tick(2);
    check_sw("cc_sw_early", 32'h0, 1'b0);
    tick();
    check_sw("cc_sw_accept", 32'h0003_FFFF, 1'b1);
    tick();

    // Reset in the middle of a count.
    sw_raw = 18'h15;
    tick(4);
    push("mid_state_count", 32'd1);
    pop_check(32'(dut.state));
    rst = 1'b1;
    #1;
    push("rst_hex_reg", 32'h0);
    pop_check(hex_reg);
    push_digits("rst", 32'h0);
    check_digits();
    check_sw("rst_sw", 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    tick(6);
    check_sw("rst_redo_early", 32'h0, 1'b0);
    tick();
    check_sw("rst_redo_accept", 32'h0000_0015, 1'b1);
    push("rst_hex_kept", 32'h0);
    pop_check(hex_reg);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
